barrel_shift_pipe: RTL
======================

Name: barrel_shift_pipe

Overview:
- Parametrised, pipelined barrel shifter. Successor to the fixed 8-bit combinational rotator.
- Supports any power-of-two WIDTH.
- Three shift modes: rotate, logical, arithmetic. Two directions: left, right.
- One register stage per shift-amount bit, with a valid/ready handshake on both sides. Intended as a datapath unit inside ALU/DSP chains that need full clock rate at large widths.

Parameters:
- WIDTH, 8, data width in bits. Must be a power of two, ≥2.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  WIDTH  word to shift.
- in_lr  in  1  direction: 0 = left, 1 = right.
- in_mode  in  2  00 rotate, 01 logical, 10 arithmetic, 11 reserved (treated as logical).
- in_sha  in  SHW  shift amount, 0..WIDTH-1.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  shifted result.

Behaviour:
- Pipeline structure:
  - SHW stages. Stage k conditionally shifts by 2^k when the captured sha[k] = 1.
  - Each stage registers data, lr, mode, the remaining sha bits, and a valid bit.
  - Latency = SHW cycles from accepted input to out_valid.
- Flow control:
  - advance = out_ready | ~out_valid.
  - in_ready = advance, combinational.
  - When advance = 1, every stage loads from its predecessor. Stage 0 loads in_valid & in_ready plus the input fields.
  - When advance = 0, all stages hold, including bubbles. Bubble compaction is not required.
  - Throughput: one word per cycle while out_ready = 1.
- Transfer rules:
  - A transfer occurs when valid & ready are both high on a clock edge.
  - out_data is stable while out_valid = 1 and out_ready = 0.
  - in_data, in_lr, in_mode and in_sha are sampled only on an input transfer.
- Mode semantics, per stage shift s = 2^k:
  - Rotate: bits wrap around; left rotate of x by s = {x[W-1-s:0], x[W-1:W-s]}.
  - Logical: vacated bits filled with 0.
  - Arithmetic right: vacated MSBs filled with in_data[WIDTH-1]. The sign bit is carried through the stages.
  - Arithmetic left: identical to logical left.
  - Mode 11: identical to logical.
- Boundary conditions:
  - sha = 0 passes data unchanged in every mode, with the same latency.
  - sha = WIDTH-1 with logical or arithmetic mode leaves one original bit or a sign fill.
  - No sha value clears data fully except zero input or a logical shift that moves out all set bits.
- Reset:
  - out_valid = 0, out_data = 0, and all stage valid bits = 0.
  - in_ready = 1 after reset, because out_valid = 0.
  - Reset asserted mid-stream discards every in-flight word. No output transfer occurs on the reset cycle.
  - Simultaneous reset and in_valid: the input is dropped.
- Simultaneous input and output transfer in the same cycle is legal and loses no data.

Optional Feature:
- Macro: BARREL_SHIFT_PIPE_FLAGS_EN.
- With the macro defined:
  - Adds output port out_zero (1 bit).
  - out_zero = (out_data == 0), registered alongside out_data in the final stage and valid only with out_valid.
  - out_zero resets to 0.
- Without the macro: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, in_data=8'hB4, rotate, right, sha=3 -> after 3 cycles out_data=8'h96, out_valid=1.
- 8'hB4, logical left, sha=2 -> 8'hD0. 8'hB4, arithmetic right, sha=2 -> 8'hED. 8'h34, arithmetic right, sha=2 -> 8'h0D.
- Streaming with out_ready tied to 1: 8 back-to-back words with sha 0..7, rotate left of 8'h01 -> outputs 8'h01, 02, 04, …, 80 on consecutive cycles, with in_ready constantly 1.
- Backpressure: out_ready=0 while out_valid=1 for 4 cycles -> out_data held, in_ready=0, no input accepted. Release -> order preserved, nothing lost or duplicated.
- Reset mid-stream: pulse reset with 2 words in flight -> out_valid=0 the following cycle, out_data=0, and the dropped words never appear.
- With BARREL_SHIFT_PIPE_FLAGS_EN defined: 8'h80, logical left, sha=7 -> out_data=8'h00, out_zero=1. The same input with rotate gives out_data=8'h40, out_zero=0.

Source files
------------

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: parametrised pipelined barrel shifter.
// One register stage per shift-amount bit; stage k shifts by 2^k when its
// captured sha bit is set. Modes: rotate, logical, arithmetic (right only),
// mode 11 behaves as logical.
// Optional feature macro: BARREL_SHIFT_PIPE_FLAGS_EN adds out_zero, a
// registered (out_data == 0) flag valid alongside out_valid.
module barrel_shift_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_lr,
   input  logic [1:0]       in_mode,
   input  logic [SHW-1:0]   in_sha,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
   output logic             out_zero,
`endif
   output logic [WIDTH-1:0] out_data
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high. The whole pipe advances in lockstep when the output register is
   // empty or being drained (advance); otherwise every stage, bubbles included,
   // holds. in_ready is that same advance term, so it is combinational from
   // out_ready and the final stage's valid bit. Input fields are only captured
   // on an input transfer; out_data is frozen while stalled.
   logic advance;

   assign advance  = out_ready | ~out_valid;
   assign in_ready = advance;

   // One power-of-two shift step. The sign fill is only used for arithmetic
   // right shifts; arithmetic left and mode 11 fall through to logical.
   function automatic logic [WIDTH-1:0] shift_by(
      input logic [WIDTH-1:0] x,
      input logic             lr,
      input logic [1:0]       mode,
      input logic             sgn,
      input int               s
   );
      logic [WIDTH-1:0] fill;
      fill = sgn ? ~({WIDTH{1'b1}} >> s) : '0;
      if (mode == 2'b00) begin
         if (lr) return (x >> s) | (x << (WIDTH - s));
         else    return (x << s) | (x >> (WIDTH - s));
      end else if (mode == 2'b10 && lr) begin
         return (x >> s) | fill;
      end else begin
         if (lr) return x >> s;
         else    return x << s;
      end
   endfunction

   for (genvar k = 0; k < SHW; k++) begin : g_stg
      localparam int S  = 1 << k;
      // Number of sha bits still needed by the stages after this one.
      localparam int RW = SHW - 1 - k;

      logic [WIDTH-1:0] src_data;
      logic [WIDTH-1:0] nxt_data;
      logic [WIDTH-1:0] data_q;
      logic             src_valid;
      logic             src_lr;
      logic             src_sgn;
      logic             src_bit;
      logic [1:0]       src_mode;
      logic             vld_q;

      if (k == 0) begin : g_in
         assign src_data  = in_data;
         assign src_valid = in_valid;
         assign src_lr    = in_lr;
         assign src_mode  = in_mode;
         assign src_sgn   = in_data[WIDTH-1];
         assign src_bit   = in_sha[0];
      end else begin : g_pipe
         assign src_data  = g_stg[k-1].data_q;
         assign src_valid = g_stg[k-1].vld_q;
         assign src_lr    = g_stg[k-1].g_meta.lr_q;
         assign src_mode  = g_stg[k-1].g_meta.mode_q;
         assign src_sgn   = g_stg[k-1].g_meta.sgn_q;
         assign src_bit   = g_stg[k-1].g_meta.sha_q[0];
      end

      assign nxt_data = src_bit ? shift_by(src_data, src_lr, src_mode, src_sgn, S)
                                : src_data;

      // Data and valid of this stage; reset clears both so out_data reads 0.
      always_ff @(posedge clk) begin
         if (reset) begin
            vld_q  <= 1'b0;
            data_q <= '0;
         end else if (advance) begin
            vld_q  <= src_valid;
            data_q <= nxt_data;
         end
      end

      // Control fields travel with the word; the last stage needs none.
      if (RW > 0) begin : g_meta
         logic          lr_q;
         logic          sgn_q;
         logic [1:0]    mode_q;
         logic [RW-1:0] sha_q;
         logic [RW-1:0] rest;

         if (k == 0) begin : g_r0
            assign rest = in_sha[SHW-1:1];
         end else begin : g_rk
            assign rest = g_stg[k-1].g_meta.sha_q[RW:1];
         end

         // Carry direction, mode, sign and remaining shift bits downstream.
         always_ff @(posedge clk) begin
            if (advance) begin
               lr_q   <= src_lr;
               sgn_q  <= src_sgn;
               mode_q <= src_mode;
               sha_q  <= rest;
            end
         end
      end
   end

   assign out_data  = g_stg[SHW-1].data_q;
   assign out_valid = g_stg[SHW-1].vld_q;

`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
   // Zero flag registered together with the word entering the final stage.
   always_ff @(posedge clk) begin
      if (reset)        out_zero <= 1'b0;
      else if (advance) out_zero <= (g_stg[SHW-1].nxt_data == '0);
   end
`endif

endmodule
